heapsort_sift_up: RTL

- Sequential sift-up stage that sits directly downstream of the HeapSort init-push stage.
- Takes the queue vector and size word just after a push has written the new element at index sz-1.
- Bubbles that element toward the root, one compare/swap per clock, to restore the min-heap property.
- Hands the repaired heap to the next stage over a valid/ready handshake.

---
 rtl/heapsort_sift_up.sv | 132 +++++++++++++
 1 files changed

// File: rtl/heapsort_sift_up.sv
// Min-heap sift-up stage. It takes a queue whose newest element sits at slot sz-1
// and moves that element toward the root, doing one compare/swap per clock.
module heapsort_sift_up #(
   parameter int DEPTH = 5,
   parameter int WIDTH = 32
) (
   input  logic                   system1000,
   input  logic                   system1000_rstn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DEPTH*WIDTH-1:0] in_qu,
   input  logic [15:0]            in_sz,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DEPTH*WIDTH-1:0] out_qu,
   output logic [15:0]            out_sz,
   output logic [3:0]             out_swaps,
   output logic                   out_err
);

   typedef enum logic [1:0] {IDLE, SIFT, DONE} state_t;

   state_t                 state_q, state_d;
   logic [DEPTH*WIDTH-1:0] qu_q, qu_d;
   logic [15:0]            sz_q, sz_d;
   logic [15:0]            idx_q, idx_d;
   logic [3:0]             swaps_q, swaps_d;
   logic                   err_q, err_d;

   logic [15:0]             parent_idx;
   logic signed [WIDTH-1:0] child_val;
   logic signed [WIDTH-1:0] parent_val;
   logic                    do_swap;

   // Slot reads go through idx/parent equality selects, so no index needs to be
   // narrowed or widened to fit the slot count.
   always_comb begin
      parent_idx = (idx_q - 16'd1) >> 1;
      child_val  = '0;
      parent_val = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (idx_q == 16'(i)) begin
            child_val = qu_q[(DEPTH-i)*WIDTH-1 -: WIDTH];
         end
         if (parent_idx == 16'(i)) begin
            parent_val = qu_q[(DEPTH-i)*WIDTH-1 -: WIDTH];
         end
      end
      do_swap = (state_q == SIFT) && (child_val < parent_val);
   end

   always_comb begin
      state_d = state_q;
      qu_d    = qu_q;
      sz_d    = sz_q;
      idx_d   = idx_q;
      swaps_d = swaps_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               qu_d    = in_qu;
               sz_d    = in_sz;
               swaps_d = 4'd0;
               if (in_sz > 16'(DEPTH)) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (in_sz <= 16'd1) begin
                  err_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  err_d   = 1'b0;
                  idx_d   = in_sz - 16'd1;
                  state_d = SIFT;
               end
            end
         end
         SIFT: begin
            if (do_swap) begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (idx_q == 16'(i)) begin
                     qu_d[(DEPTH-i)*WIDTH-1 -: WIDTH] = parent_val;
                  end
                  if (parent_idx == 16'(i)) begin
                     qu_d[(DEPTH-i)*WIDTH-1 -: WIDTH] = child_val;
                  end
               end
               swaps_d = (swaps_q == 4'd15) ? 4'd15 : swaps_q + 4'd1;
               idx_d   = parent_idx;
               if (parent_idx == 16'd0) begin
                  state_d = DONE;
               end
            end else begin
               // An equal parent also stops the climb, so equal keys keep their order.
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         state_q <= IDLE;
         qu_q    <= '0;
         sz_q    <= '0;
         idx_q   <= '0;
         swaps_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         qu_q    <= qu_d;
         sz_q    <= sz_d;
         idx_q   <= idx_d;
         swaps_q <= swaps_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_qu    = qu_q;
   assign out_sz    = sz_q;
   assign out_swaps = swaps_q;
   assign out_err   = err_q;

endmodule
